// File: rtl/picorv_native_dma.sv
// picorv_native_dma: word-copy DMA initiator on the PicoRV32 native memory bus.
// Alternates read/write transactions with one idle cycle after every completion.
module picorv_native_dma #(
    parameter int TIMEOUT = 1024,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, READ, GAP_R, WRITE, GAP_W, FIN} state_t;

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] cnt;
    logic [TW-1:0]    tcnt;

    assign mem_instr = 1'b0;

    // mem_wdata doubles as the word buffer between the read and the write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    src   <= src_addr & ~32'h3;
                    dst   <= dst_addr & ~32'h3;
                    cnt   <= len_words;
                    error <= 1'b0;
                    busy  <= 1'b1;
                    if (len_words == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state     <= READ;
                        mem_valid <= 1'b1;
                        mem_addr  <= src_addr & ~32'h3;
                        mem_wstrb <= 4'h0;
                        tcnt      <= '0;
                    end
                end
                READ: if (mem_ready) begin
                    mem_wdata <= mem_rdata;
                    mem_valid <= 1'b0;
                    state     <= GAP_R;
                end else if (tcnt == TMAX) begin
                    mem_valid <= 1'b0;
                    error     <= 1'b1;
                    done      <= 1'b1;
                    state     <= FIN;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                GAP_R: begin
                    state     <= WRITE;
                    mem_valid <= 1'b1;
                    mem_addr  <= dst;
                    mem_wstrb <= 4'hf;
                    tcnt      <= '0;
                end
                WRITE: if (mem_ready) begin
                    mem_valid <= 1'b0;
                    mem_wstrb <= 4'h0;
                    cnt       <= cnt - 1'b1;
                    src       <= src + 32'd4;
                    dst       <= dst + 32'd4;
                    state     <= (cnt == LEN_W'(1)) ? FIN : GAP_W;
                    done      <= (cnt == LEN_W'(1));
                end else if (tcnt == TMAX) begin
                    mem_valid <= 1'b0;
                    mem_wstrb <= 4'h0;
                    error     <= 1'b1;
                    done      <= 1'b1;
                    state     <= FIN;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                GAP_W: begin
                    state     <= READ;
                    mem_valid <= 1'b1;
                    mem_addr  <= src;
                    mem_wstrb <= 4'h0;
                    tcnt      <= '0;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_picorv_native_dma.sv
// tb_picorv_native_dma: randomized scoreboard bench with a native-bus RAM responder.
// Expected transactions come from a word-level copy model on a shadow memory.
module tb_picorv_native_dma;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy, done, error, mem_valid, mem_instr;
    logic             mem_ready = 1'b0;
    logic [31:0]      mem_addr, mem_wdata;
    logic [31:0]      mem_rdata = '0;
    logic [3:0]       mem_wstrb;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } txn_t;

    txn_t        q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    int          checks = 0, errors = 0, ntx = 0, wait_sum = 0;
    int          mode = 0, fixed_wait = 0, vcnt = 0, waits = 0;
    bit          noise = 1'b0, rdy_live = 1'b0, prev_done = 1'b0, prev_pend = 1'b0;
    logic [67:0] prev_bus = '0;

    picorv_native_dma #(.TIMEOUT(16), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len_words(len_words), .busy(busy), .done(done),
        .error(error), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5a5a_a5a5);
    endfunction

    function automatic logic [31:0] srd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : (a ^ 32'h5a5a_a5a5);
    endfunction

    // responder: mode 0 zero-wait, 1 random 0-7 waits, 2 fixed waits, 3 never ready
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            mem_ready = 1'b0;
            rdy_live  = 1'b0;
            vcnt      = 0;
        end else if (rdy_live) begin
            mem_ready = 1'b0;
            rdy_live  = 1'b0;
            vcnt      = 0;
            mem_rdata = $urandom;
        end else if (mem_valid) begin
            vcnt++;
            if (vcnt == 1) begin
                waits = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(0, 7)) :
                        (mode == 2) ? fixed_wait : 32'h4000_0000;
                if (mode != 3) wait_sum += waits;
            end
            mem_ready = 1'b0;
            if (mode != 3 && vcnt >= waits + 2) begin
                mem_ready = 1'b1;
                rdy_live  = 1'b1;
                if (mem_wstrb == 4'hf) mem[mem_addr] = mem_wdata;
                else mem_rdata = rd(mem_addr);
            end
        end else begin
            vcnt      = 0;
            mem_ready = noise && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
        end
    end

    // monitor: pops the scoreboard on every completed transaction and checks bus rules
    always @(negedge clk) begin
        txn_t e;
        if (mem_valid) chk("mem_instr", mem_instr, 0);
        if (prev_done) chk("gap_after_completion", mem_valid, 0);
        if (prev_pend && mem_valid) chk("hold_while_waiting", {mem_addr, mem_wdata, mem_wstrb}, prev_bus);
        if (mem_valid && mem_ready) begin
            ntx++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_txn: got addr %h wstrb %h, required no transaction", mem_addr, mem_wstrb);
            end else begin
                e = q.pop_front();
                chk("txn_addr", mem_addr, e.a);
                chk("txn_wstrb", mem_wstrb, e.s);
                if (e.s == 4'hf) chk("txn_wdata", mem_wdata, e.d);
            end
        end
        prev_done = mem_valid && mem_ready;
        prev_pend = mem_valid && !mem_ready;
        prev_bus  = {mem_addr, mem_wdata, mem_wstrb};
    end

    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input bit poke, input bit abort);
        logic [31:0] sa, da, v;
        int cyc;
        bit seen, anyv;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        for (int i = 0; i < n; i++) begin
            v = srd(sa);
            q.push_back('{sa, 4'h0, 32'h0});
            q.push_back('{da, 4'hf, v});
            shadow[da] = v;
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
        wait_sum = 0;
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = LEN_W'(n); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len_words = LEN_W'($urandom);
        cyc = 0; seen = 1'b0; anyv = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            anyv |= mem_valid;
            if (cyc == 1) begin
                chk("busy_cycle1", busy, 1);
                chk("valid_cycle1", mem_valid, n > 0);
                chk("error_cleared_by_start", error, 0);
            end
            if (poke && cyc == 4) start = 1'b1;
            if (poke && cyc == 6) start = 1'b0;
            if (abort && cyc > 8 && mem_valid && mem_wstrb == 4'hf) begin
                #2 resetn = 1'b0;
                #1 chk("async_reset_outputs", {mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error}, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("no_done_in_reset", done, 0);
                end
                q.delete();
                shadow = mem;
                resetn = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("idle_after_reset", {busy, done}, 0);
                end
                return;
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_never_seen: got no done in %0d cycles, required done", cyc);
        end
        chk("done_cycle", cyc, (n == 0) ? 1 : 6 * n + wait_sum);
        chk("error_at_done", error, 0);
        chk("scoreboard_drained", q.size(), 0);
        if (n == 0) chk("len0_no_valid", anyv, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int n0, cyc, vc;
        bit seen;
        logic [31:0] s, d;
        repeat (2) @(negedge clk);
        chk("reset_state", {mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_instr, busy, done, error}, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            mem[32'h4000_0000 + 4 * i]    = 32'h1111_1111 * (i + 1);
            shadow[32'h4000_0000 + 4 * i] = 32'h1111_1111 * (i + 1);
        end
        n0 = ntx;
        run(32'h4000_0000, 32'h4000_1000, 4, 1'b0, 1'b0);
        chk("txn_count", ntx - n0, 8);
        for (int i = 0; i < 4; i++) chk("dest_word", rd(32'h4000_1000 + 4 * i), 32'h1111_1111 * (i + 1));

        run(32'h4000_0000, 32'h4000_2000, 0, 1'b0, 1'b0);

        mode = 1; noise = 1'b1;
        s = 32'h1000_0000 + ($urandom & 32'hfff);
        d = 32'h2000_0000 + ($urandom & 32'hfff);
        run(s, d, 16, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) chk("random_copy_word", rd((d & ~32'h3) + 4 * i), srd((d & ~32'h3) + 4 * i));

        mode = 3; noise = 1'b0;
        @(negedge clk);
        src_addr = 32'h5000_0000; dst_addr = 32'h5000_1000; len_words = 3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; vc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_valid) vc++;
            if (done) begin
                seen = 1'b1;
                chk("timeout_error", error, 1);
            end
        end
        chk("timeout_valid_cycles", vc, 16);
        chk("timeout_done_cycle", cyc, 17);
        repeat (3) @(negedge clk);
        chk("error_sticky", {error, busy}, 2'b10);
        mode = 0;
        run(32'h5000_0000, 32'h5000_1000, 0, 1'b0, 1'b0);

        mode = 2; fixed_wait = 14;
        run(32'h6000_0000, 32'h6000_1000, 1, 1'b0, 1'b0);

        mode = 0;
        run(32'hffff_fffe, 32'h3000_0002, 2, 1'b1, 1'b0);

        mode = 1; noise = 1'b1;
        run(32'h7000_0000, 32'h7000_1000, 8, 1'b0, 1'b1);
        mode = 0; noise = 1'b0;
        run(32'h7100_0000, 32'h7100_1000, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) chk("post_reset_copy_word", rd(32'h7100_1000 + 4 * i), 32'h7100_0000 + 4 * i ^ 32'h5a5a_a5a5);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
